coin_credit_accumulator: RTL and testbench
==========================================

Name: coin_credit_accumulator

Overview:
- Upstream input stage for the vending machine controller. Conditions the raw quarter, dollar, card and cancel push-buttons: 2-flop synchroniser, debounce, rising-edge detect.
- Keeps a running credit in cents and arbitrates purchases through a 4-phase req/ack/nak handshake with the downstream dispense logic.
- Returns unused credit as a one-cycle change pulse on cancel.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before a button state change is accepted (10 ms at 100 MHz).
- CREDIT_W, 11: width of credit, price and change buses, in cents.
- MAX_CREDIT, 1000: maximum credit in cents.
- QUARTER_VAL, 25: cents added per quarter event.
- DOLLAR_VAL, 100: cents added per dollar event.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- quarter_btn  in  1  raw, asynchronous, bouncing.
- dollar_btn  in  1  raw, asynchronous, bouncing.
- card_btn  in  1  raw, asynchronous, bouncing.
- cancel_btn  in  1  raw, asynchronous, bouncing.
- vend_req  in  1  purchase request, level, from downstream.
- vend_price  in  CREDIT_W  item price; stable while vend_req is high.
- vend_ack  out  1  purchase granted; held until vend_req falls.
- vend_nak  out  1  purchase refused; held until vend_req falls.
- credit  out  CREDIT_W  current credit in cents.
- card_active  out  1  a card tap is pending.
- coin_reject  out  1  one-cycle pulse: coin refused because it would exceed MAX_CREDIT.
- change_valid  out  1  one-cycle pulse: refund issued.
- change_amount  out  CREDIT_W  refund value; valid only while change_valid is high, otherwise 0.

Behaviour:
- Reset (async assert, sync release): all outputs 0, credit 0, FSM IDLE, debounced states 0, debounce counters 0.
- Conditioning, per button:
  - 2-flop synchroniser feeds a debounce counter.
  - Counter clears whenever the synced input equals the debounced state.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES-1 the debounced state flips and the counter clears.
  - A debounced 0->1 transition produces a one-cycle event. Holding a button produces exactly one event; release produces none.
  - Latency from a clean raw edge to its event: 2 + DEBOUNCE_CYCLES cycles.
- Credit update each cycle: tmp = credit - deduct (deduct = vend_price when the CHECK state grants from cash, else 0).
  - Quarter event: if tmp + QUARTER_VAL <= MAX_CREDIT, add it; otherwise pulse coin_reject and leave tmp unchanged.
  - Dollar event: same rule with DOLLAR_VAL.
  - Quarter and dollar events in the same cycle: apply quarter first, then dollar, each checked independently. coin_reject pulses if either is refused.
  - All arithmetic is unsigned CREDIT_W. Credit never exceeds MAX_CREDIT and never underflows.
- Card event: set card_active. A repeated event while already set has no effect.
- Vend FSM, states IDLE, CHECK, RESP:
  - IDLE: vend_req = 1 -> CHECK.
  - CHECK, one cycle:
    - If card_active: assert vend_ack, clear card_active, credit unchanged.
    - Else if credit >= vend_price: assert vend_ack, deduct vend_price.
    - Else: assert vend_nak.
    - Always -> RESP.
  - RESP: hold ack/nak. When vend_req = 0, deassert both -> IDLE.
  - vend_req must not be reasserted before ack/nak has dropped.
  - Price 0 paid from cash: grant, credit unchanged.
- Cancel event:
  - Honoured only in IDLE: change_valid = 1 and change_amount = credit for one cycle; credit := 0; card_active := 0.
  - With credit 0 it still pulses, with amount 0.
  - A coin event in the same cycle is applied after the zeroing, so credit = coin value.
  - Cancel in CHECK or RESP is discarded.
- Reset mid-handshake: ack/nak drop immediately and credit is lost. Downstream must restart its request.

Test Plan (sim DEBOUNCE_CYCLES=4):
- Reset, then 3 clean quarter presses each held 20 cycles -> credit 25, 50, 75; exactly 3 events; coin_reject never pulses.
- Quarter input toggling every cycle for 10 cycles, then held high -> exactly one +25 only after 4 stable synced cycles.
- Dollar x2, vend_req with price 150 -> vend_ack in CHECK+1, credit 50; drop req -> ack low next cycle, FSM IDLE.
- Credit 50, vend_req with price 75 -> vend_nak held until req falls; credit stays 50.
- Credit 975, dollar then quarter -> first pulses coin_reject with credit 975; second gives credit 1000.
- Card tap, credit 25, vend price 200 -> ack, credit 25, card_active 0; then cancel -> change_valid one cycle with amount 25, credit 0.

Source files
------------

// File: rtl/coin_credit_accumulator.sv
// Coin/card credit front end for the vending controller.
// Conditions four raw push-buttons (synchronise, debounce, rising-edge
// detect), keeps a running credit in cents, arbitrates purchases over a
// req/ack/nak handshake and returns unused credit on cancel.
module coin_credit_accumulator #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CREDIT_W        = 11,
    parameter int unsigned MAX_CREDIT      = 1000,
    parameter int unsigned QUARTER_VAL     = 25,
    parameter int unsigned DOLLAR_VAL      = 100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                quarter_btn,
    input  logic                dollar_btn,
    input  logic                card_btn,
    input  logic                cancel_btn,
    input  logic                vend_req,
    input  logic [CREDIT_W-1:0] vend_price,
    output logic                vend_ack,
    output logic                vend_nak,
    output logic [CREDIT_W-1:0] credit,
    output logic                card_active,
    output logic                coin_reject,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount
);

    localparam int unsigned NBTN  = 4;
    localparam int unsigned B_QTR = 0;
    localparam int unsigned B_DOL = 1;
    localparam int unsigned B_CRD = 2;
    localparam int unsigned B_CAN = 3;

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CREDIT_W:0] QTR_W    = (CREDIT_W+1)'(QUARTER_VAL);
    localparam logic [CREDIT_W:0] DOL_W    = (CREDIT_W+1)'(DOLLAR_VAL);
    localparam logic [CREDIT_W:0] MAX_W    = (CREDIT_W+1)'(MAX_CREDIT);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        RESP
    } state_t;

    logic [NBTN-1:0]  raw;
    logic [NBTN-1:0]  sync1;
    logic [NBTN-1:0]  sync2;
    logic [NBTN-1:0]  deb;
    logic [NBTN-1:0]  deb_next;
    logic [NBTN-1:0]  evt;
    logic [CNT_W-1:0] cnt      [NBTN];
    logic [CNT_W-1:0] cnt_next [NBTN];

    state_t state, state_next;
    logic   ack_next, nak_next;
    logic   grant_cash, grant_card;

    logic [CREDIT_W-1:0] credit_next;
    logic [CREDIT_W-1:0] tmp;
    logic [CREDIT_W:0]   sum_q, sum_d;
    logic                cancel_ok;
    logic                reject_next;
    logic                card_next;
    logic [CREDIT_W-1:0] chg_amt_next;

    assign raw = {cancel_btn, card_btn, dollar_btn, quarter_btn};

    // Two-flop synchroniser for the asynchronous button inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce counters; the event fires in the cycle the debounced state rises,
    // so credit changes on the same edge that the debounced state flips
    always_comb begin
        deb_next = deb;
        evt      = '0;
        for (int unsigned i = 0; i < NBTN; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != deb[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    deb_next[i] = sync2[i];
                    evt[i]      = sync2[i];
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // Debounced state and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= '0;
            for (int unsigned i = 0; i < NBTN; i++) cnt[i] <= '0;
        end else begin
            deb <= deb_next;
            for (int unsigned i = 0; i < NBTN; i++) cnt[i] <= cnt_next[i];
        end
    end

    // Vend FSM next-state and handshake decisions
    always_comb begin
        state_next = state;
        ack_next   = vend_ack;
        nak_next   = vend_nak;
        grant_cash = 1'b0;
        grant_card = 1'b0;
        case (state)
            IDLE: begin
                if (vend_req) state_next = CHECK;
            end
            CHECK: begin
                if (card_active) begin
                    ack_next   = 1'b1;
                    grant_card = 1'b1;
                end else if (credit >= vend_price) begin
                    ack_next   = 1'b1;
                    grant_cash = 1'b1;
                end else begin
                    nak_next = 1'b1;
                end
                state_next = RESP;
            end
            RESP: begin
                if (!vend_req) begin
                    ack_next   = 1'b0;
                    nak_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Credit: deduct, then cancel zeroing, then quarter, then dollar
    always_comb begin
        tmp          = credit - (grant_cash ? vend_price : '0);
        cancel_ok    = evt[B_CAN] && (state == IDLE);
        chg_amt_next = cancel_ok ? credit : '0;
        reject_next  = 1'b0;
        sum_q        = '0;
        sum_d        = '0;
        if (cancel_ok) tmp = '0;
        if (evt[B_QTR]) begin
            sum_q = {1'b0, tmp} + QTR_W;
            if (sum_q <= MAX_W) tmp = sum_q[CREDIT_W-1:0];
            else                reject_next = 1'b1;
        end
        if (evt[B_DOL]) begin
            sum_d = {1'b0, tmp} + DOL_W;
            if (sum_d <= MAX_W) tmp = sum_d[CREDIT_W-1:0];
            else                reject_next = 1'b1;
        end
        credit_next = tmp;

        card_next = card_active;
        if (evt[B_CRD] && !card_active) card_next = 1'b1;
        if (grant_card || cancel_ok)    card_next = 1'b0;
    end

    // State, credit and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            vend_ack      <= 1'b0;
            vend_nak      <= 1'b0;
            credit        <= '0;
            card_active   <= 1'b0;
            coin_reject   <= 1'b0;
            change_valid  <= 1'b0;
            change_amount <= '0;
        end else begin
            state         <= state_next;
            vend_ack      <= ack_next;
            vend_nak      <= nak_next;
            credit        <= credit_next;
            card_active   <= card_next;
            coin_reject   <= reject_next;
            change_valid  <= cancel_ok;
            change_amount <= chg_amt_next;
        end
    end

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// Directed bench for coin_credit_accumulator with a short debounce window.
module tb_coin_credit_accumulator;

    localparam int unsigned CW = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    btns;
    logic          vend_req;
    logic [CW-1:0] vend_price;
    logic          vend_ack, vend_nak, card_active, coin_reject, change_valid;
    logic [CW-1:0] credit, change_amount;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned rej_cnt = 0;
    int unsigned chg_cnt = 0;
    logic [CW-1:0] last_amt = '0;

    coin_credit_accumulator #(
        .DEBOUNCE_CYCLES(4),
        .CREDIT_W(CW),
        .MAX_CREDIT(1000),
        .QUARTER_VAL(25),
        .DOLLAR_VAL(100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .quarter_btn(btns[0]),
        .dollar_btn(btns[1]),
        .card_btn(btns[2]),
        .cancel_btn(btns[3]),
        .vend_req(vend_req),
        .vend_price(vend_price),
        .vend_ack(vend_ack),
        .vend_nak(vend_nak),
        .credit(credit),
        .card_active(card_active),
        .coin_reject(coin_reject),
        .change_valid(change_valid),
        .change_amount(change_amount)
    );

    always #5 clk = ~clk;

    // Pulse monitors sampled away from the active edge
    always @(negedge clk) begin
        if (rst_n && coin_reject) rej_cnt++;
        if (rst_n && change_valid) begin
            chg_cnt++;
            last_amt = change_amount;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input int unsigned which);
        btns[which] = 1'b1;
        repeat (20) @(negedge clk);
        btns[which] = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        btns       = '0;
        vend_req   = 1'b0;
        vend_price = '0;
        repeat (3) @(negedge clk);
        check("rst_credit", 32'(credit), 0);
        check("rst_ack", 32'(vend_ack), 0);
        check("rst_nak", 32'(vend_nak), 0);
        check("rst_card", 32'(card_active), 0);
        check("rst_change_valid", 32'(change_valid), 0);
        check("rst_coin_reject", 32'(coin_reject), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three clean quarters
        press(0); check("q1_credit", 32'(credit), 25);
        press(0); check("q2_credit", 32'(credit), 50);
        press(0); check("q3_credit", 32'(credit), 75);
        check("q_no_reject", rej_cnt, 0);

        // Bouncing quarter: no event while toggling, one event after settling
        for (int i = 0; i < 10; i++) begin
            btns[0] = ~btns[0];
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("bounce_no_event", 32'(credit), 75);
        btns[0] = 1'b1;
        repeat (5) @(negedge clk);
        check("bounce_before_latency", 32'(credit), 75);
        @(negedge clk);
        check("bounce_at_latency", 32'(credit), 100);
        repeat (20) @(negedge clk);
        check("hold_single_event", 32'(credit), 100);
        btns[0] = 1'b0;
        repeat (20) @(negedge clk);
        check("release_no_event", 32'(credit), 100);

        // Cancel in IDLE refunds everything
        press(3);
        check("cancel1_pulses", chg_cnt, 1);
        check("cancel1_amount", 32'(last_amt), 100);
        check("cancel1_credit", 32'(credit), 0);
        check("change_amount_idle", 32'(change_amount), 0);

        // Cash purchase, granted
        press(1); press(1);
        check("dollars_credit", 32'(credit), 200);
        vend_price = 11'd150;
        vend_req   = 1'b1;
        @(negedge clk);
        check("buy_ack_in_check", 32'(vend_ack), 0);
        @(negedge clk);
        check("buy_ack", 32'(vend_ack), 1);
        check("buy_credit", 32'(credit), 50);
        repeat (3) @(negedge clk);
        check("buy_ack_held", 32'(vend_ack), 1);
        vend_req = 1'b0;
        @(negedge clk);
        check("buy_ack_drop", 32'(vend_ack), 0);
        check("buy_nak", 32'(vend_nak), 0);

        // Cash purchase, refused; cancel during RESP is discarded
        vend_price = 11'd75;
        vend_req   = 1'b1;
        repeat (2) @(negedge clk);
        check("nak_set", 32'(vend_nak), 1);
        check("nak_no_ack", 32'(vend_ack), 0);
        press(3);
        check("nak_held", 32'(vend_nak), 1);
        check("nak_credit", 32'(credit), 50);
        check("cancel_in_resp_ignored", chg_cnt, 1);
        vend_req = 1'b0;
        @(negedge clk);
        check("nak_drop", 32'(vend_nak), 0);

        // Fill to 975, then overflow boundary
        for (int i = 0; i < 9; i++) press(1);
        press(0);
        check("fill_975", 32'(credit), 975);
        press(1);
        check("dollar_rejected_pulse", rej_cnt, 1);
        check("dollar_rejected_credit", 32'(credit), 975);
        press(0);
        check("quarter_to_max", 32'(credit), 1000);
        check("quarter_to_max_no_reject", rej_cnt, 1);
        press(0);
        check("quarter_over_max", rej_cnt, 2);
        check("quarter_over_max_credit", 32'(credit), 1000);

        press(3);
        check("cancel2_amount", 32'(last_amt), 1000);
        check("cancel2_credit", 32'(credit), 0);

        // Card purchase leaves cash untouched
        press(0);
        press(2);
        check("card_set", 32'(card_active), 1);
        vend_price = 11'd200;
        vend_req   = 1'b1;
        repeat (2) @(negedge clk);
        check("card_ack", 32'(vend_ack), 1);
        check("card_credit", 32'(credit), 25);
        check("card_cleared", 32'(card_active), 0);
        vend_req = 1'b0;
        @(negedge clk);
        press(3);
        check("cancel3_pulses", chg_cnt, 3);
        check("cancel3_amount", 32'(last_amt), 25);
        check("cancel3_credit", 32'(credit), 0);

        // Zero price from cash is granted
        vend_price = 11'd0;
        vend_req   = 1'b1;
        repeat (2) @(negedge clk);
        check("zero_price_ack", 32'(vend_ack), 1);
        check("zero_price_credit", 32'(credit), 0);
        vend_req = 1'b0;
        @(negedge clk);

        // Reset mid-handshake drops ack and credit immediately
        press(0);
        vend_price = 11'd10;
        vend_req   = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_reset_credit", 32'(credit), 15);
        #2 rst_n = 1'b0;
        #1;
        check("reset_ack_drop", 32'(vend_ack), 0);
        check("reset_credit", 32'(credit), 0);
        vend_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
